regfile_wb_arbiter: RTL and testbench

//   Drives the register file write port (we3/a3/wd3) from two writeback producers:

---
 rtl/regfile_wb_arbiter.sv | 96 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU (A) and buffered long-latency (B) writebacks onto the regfile write port
module regfile_wb_arbiter #(
    parameter int DEPTH     = 4,
    parameter int MAX_DEFER = 3,
    parameter int DATA_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [4:0]                 a_rd,
    input  logic [DATA_W-1:0]          a_data,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [4:0]                 b_rd,
    input  logic [DATA_W-1:0]          b_data,
    output logic                       wb_we,
    output logic [4:0]                 wb_addr,
    output logic [DATA_W-1:0]          wb_data,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic [31:0]                pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int DW = $clog2(MAX_DEFER+1);

    typedef enum logic {NORMAL, FORCE_B} state_t;

    state_t              state;
    logic [AW-1:0]       wptr, rptr;
    logic [4:0]          rd_mem   [DEPTH];
    logic [DATA_W-1:0]   data_mem [DEPTH];
    logic [DW-1:0]       defer_cnt, defer_nxt;
    logic [CW-1:0]       count_nxt;
    logic                empty, push, pop, take_a, sel, write;
    logic [4:0]          sel_rd;
    logic [DATA_W-1:0]   sel_data;

    assign empty     = fifo_count == '0;
    assign a_ready   = rst_n && state == NORMAL;
    assign b_ready   = rst_n && fifo_count < CW'(DEPTH);
    assign push      = b_valid && b_ready;
    assign take_a    = a_valid && a_ready;
    assign pop       = !empty && (state == FORCE_B || !a_valid);
    assign sel       = take_a || pop;
    assign sel_rd    = take_a ? a_rd : rd_mem[rptr];
    assign sel_data  = take_a ? a_data : data_mem[rptr];
    assign write     = sel && sel_rd != 5'd0;
    assign count_nxt = fifo_count + CW'(push) - CW'(pop);
    assign defer_nxt = take_a ? (empty ? '0 : defer_cnt + DW'(1)) : (pop ? '0 : defer_cnt);

    // FIFO storage needs no reset: validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wptr]   <= b_rd;
            data_mem[wptr] <= b_data;
        end
    end

    // Pointers, arbitration FSM and the registered regfile write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= NORMAL;
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            defer_cnt  <= '0;
            wb_we      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            fifo_count <= count_nxt;
            defer_cnt  <= defer_nxt;
            state      <= (state == NORMAL && defer_nxt == DW'(MAX_DEFER) && count_nxt != '0) ? FORCE_B : NORMAL;
            wb_we      <= write;
            if (write) begin
                wb_addr <= sel_rd;
                wb_data <= sel_data;
            end
        end
    end

    // Destinations of every buffered B entry; x0 is never a hazard
    always_comb begin
        logic [AW-1:0] off;
        pending = '0;
        off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rptr;
            if (CW'(off) < fifo_count) pending[rd_mem[i]] = 1'b1;
        end
        pending[0] = 1'b0;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench with a queue-based reference model
module tb_regfile_wb_arbiter;
    localparam int DEPTH     = 4;
    localparam int MAX_DEFER = 3;
    localparam int DATA_W    = 32;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       a_valid, a_ready, b_valid, b_ready, wb_we;
    logic [4:0]                 a_rd, b_rd, wb_addr;
    logic [DATA_W-1:0]          a_data, b_data, wb_data;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    logic [31:0]                pending;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_DEFER(MAX_DEFER), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .fifo_count(fifo_count), .pending(pending)
    );

    typedef struct {logic [4:0] rd; logic [31:0] data;} ent_t;
    typedef struct {logic [4:0] rd; logic [31:0] data; int cyc;} wr_t;

    ent_t bq[$];
    wr_t  exp_q[$];
    int   streak = 0;
    bit   force_b = 0;
    int   cycle_cnt = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cycle_cnt);
        end
    endtask

    // Monitor: every cycle, a write is due exactly when the scoreboard head is stamped for it
    initial forever begin
        bit  due;
        wr_t w;
        @(posedge clk);
        cycle_cnt++;
        #1;
        if (rst_n) begin
            due = exp_q.size() > 0 && exp_q[0].cyc == cycle_cnt;
            chk("wb_we", wb_we, due);
            if (due) begin
                w = exp_q.pop_front();
                if (wb_we) begin
                    chk("wb_addr", wb_addr, w.rd);
                    chk("wb_data", wb_data, w.data);
                end
            end
        end
    end

    // One cycle of stimulus; the model predicts handshakes and queues the resulting write
    task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit bv, input logic [4:0] brd, input logic [31:0] bd);
        logic [31:0] pend;
        bit          a_rdy, b_rdy, sel;
        ent_t        e;
        @(negedge clk);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
        #1;
        a_rdy = !force_b;
        b_rdy = bq.size() < DEPTH;
        pend  = '0;
        foreach (bq[i]) pend[bq[i].rd] = 1'b1;
        pend[0] = 1'b0;
        chk("a_ready", a_ready, a_rdy);
        chk("b_ready", b_ready, b_rdy);
        chk("fifo_count", fifo_count, bq.size());
        chk("pending", pending, pend);
        sel = 0;
        e   = '{rd: 5'd0, data: 32'd0};
        if (force_b) begin
            e = bq.pop_front(); sel = 1; streak = 0; force_b = 0;
        end else if (av) begin
            e.rd = ard; e.data = ad; sel = 1;
            streak = bq.size() > 0 ? streak + 1 : 0;
        end else if (bq.size() > 0) begin
            e = bq.pop_front(); sel = 1; streak = 0;
        end
        if (sel && e.rd != 5'd0) exp_q.push_back(wr_t'{rd: e.rd, data: e.data, cyc: cycle_cnt + 1});
        if (bv && b_rdy) bq.push_back(ent_t'{rd: brd, data: bd});
        force_b = streak == MAX_DEFER && bq.size() > 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_valid = 0; b_valid = 0;
        #1;
        chk("rst_wb_we", wb_we, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_pending", pending, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        bq.delete(); exp_q.delete();
        streak = 0; force_b = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        a_valid = 0; a_rd = '0; a_data = '0;
        b_valid = 0; b_rd = '0; b_data = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("init_wb_we", wb_we, 0);
        chk("init_wb_addr", wb_addr, 0);
        chk("init_wb_data", wb_data, 0);
        chk("init_fifo_count", fifo_count, 0);
        chk("init_pending", pending, 0);
        chk("init_a_ready", a_ready, 0);
        chk("init_b_ready", b_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // A-only write then idle
        step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
        idle(2);
        // A write to x0 is accepted and dropped
        step(1, 5'd0, 32'h1234, 0, 5'd0, 32'd0);
        idle(2);
        // B-only stream drains in order
        for (int r = 1; r <= 4; r++) step(0, 5'd0, 32'd0, 1, 5'(r), 32'h100 + r);
        idle(3);
        // A held while B fills: 3 A wins then one forced B, repeating
        for (int i = 0; i < 4; i++) step(1, 5'(11 + i), 32'hA0 + i, 1, 5'(7 + i), 32'hB0 + i);
        for (int i = 0; i < 14; i++) step(1, 5'(15 + i), 32'hC0 + i, 1, 5'(1 + i), 32'hE0 + i);
        idle(6);
        // Simultaneous push and pop at count 2
        step(1, 5'd20, 32'h20, 1, 5'd21, 32'h21);
        step(1, 5'd22, 32'h22, 1, 5'd23, 32'h23);
        step(0, 5'd0, 32'd0, 1, 5'd24, 32'h24);
        step(0, 5'd0, 32'd0, 1, 5'd25, 32'h25);
        idle(4);
        // Reset with three entries buffered
        for (int i = 0; i < 3; i++) step(1, 5'(1 + i), 32'h300 + i, 1, 5'(4 + i), 32'h400 + i);
        do_reset();
        idle(3);
        // Randomized traffic with one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
        end
        idle(10);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
